// File: rtl/cache_axi_rd_arb_if.sv
// Bus bundle for cache_axi_rd_arb: packed per-master AR/R lines on the cache side
// and a single AXI3 read channel on the memory side.
interface cache_axi_rd_arb_if #(
  parameter int N_MASTERS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [N_MASTERS-1:0]            m_arvalid;
  logic [N_MASTERS-1:0]            m_arready;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr;
  logic [N_MASTERS*4-1:0]          m_arlen;
  logic [N_MASTERS*3-1:0]          m_arsize;
  logic [N_MASTERS*2-1:0]          m_arburst;
  logic [N_MASTERS*ID_WIDTH-1:0]   m_arid;
  logic [N_MASTERS-1:0]            m_rvalid;
  logic [N_MASTERS-1:0]            m_rready;
  logic [DATA_WIDTH-1:0]           m_rdata;
  logic [1:0]                      m_rresp;
  logic                            m_rlast;
  logic [ID_WIDTH-1:0]             m_rid;

  logic                            s_arvalid;
  logic                            s_arready;
  logic [ADDR_WIDTH-1:0]           s_araddr;
  logic [3:0]                      s_arlen;
  logic [2:0]                      s_arsize;
  logic [1:0]                      s_arburst;
  logic [ID_WIDTH-1:0]             s_arid;
  logic                            s_rvalid;
  logic                            s_rready;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic [1:0]                      s_rresp;
  logic                            s_rlast;
  logic [ID_WIDTH-1:0]             s_rid;

  // The arbiter serves the cache masters, hence it takes the slave view.
  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid, s_rready
  );

  modport master (
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid, s_rready
  );
endinterface

// File: rtl/cache_axi_rd_arb.sv
// N-master AXI3 read arbiter, one burst outstanding; fixed priority by default,
// round-robin when CACHE_AXI_RD_ARB_RR_EN is defined.
module cache_axi_rd_arb #(
  parameter int N_MASTERS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_axi_rd_arb_if.slave bus,
  output logic              busy,
  output logic              len_err
);
  localparam int GW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d, reqIdx;
  logic                  reqAny;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [3:0]            beat_q, beat_d;
  logic                  len_err_q, len_err_d;
  logic                  beatAccept;
`ifdef CACHE_AXI_RD_ARB_RR_EN
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [GW:0]           candW;
`endif

  assign reqAny     = |bus.m_arvalid;
  assign beatAccept = (state_q == DATA) && bus.s_rvalid && bus.m_rready[grant_q];

  always_comb begin
    reqIdx = '0;
`ifdef CACHE_AXI_RD_ARB_RR_EN
    candW = '0;
    // Scan backwards so the first requester at or after the pointer wins.
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      candW = {1'b0, ptr_q} + (GW+1)'(i);
      if (candW >= (GW+1)'(N_MASTERS)) candW = candW - (GW+1)'(N_MASTERS);
      if (bus.m_arvalid[candW[GW-1:0]]) reqIdx = candW[GW-1:0];
    end
`else
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (bus.m_arvalid[i]) reqIdx = GW'(i);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (reqAny) state_d = ADDR;
      ADDR:    if (bus.s_arready) state_d = DATA;
      DATA:    if (beatAccept && bus.s_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arid_d    = arid_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
`ifdef CACHE_AXI_RD_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    if (state_q == IDLE && reqAny) begin
      grant_d   = reqIdx;
      araddr_d  = bus.m_araddr[reqIdx*ADDR_WIDTH +: ADDR_WIDTH];
      arlen_d   = bus.m_arlen[reqIdx*4 +: 4];
      arsize_d  = bus.m_arsize[reqIdx*3 +: 3];
      arburst_d = bus.m_arburst[reqIdx*2 +: 2];
      arid_d    = bus.m_arid[reqIdx*ID_WIDTH +: ID_WIDTH];
    end
    if (state_q == ADDR && bus.s_arready) beat_d = '0;
    // The beat index before increment must equal arlen exactly on the rlast beat.
    if (beatAccept) begin
      beat_d = beat_q + 4'd1;
      if (bus.s_rlast != (beat_q == arlen_q)) len_err_d = 1'b1;
    end
`ifdef CACHE_AXI_RD_ARB_RR_EN
    if (beatAccept && bus.s_rlast)
      ptr_d = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arid_q    <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
`ifdef CACHE_AXI_RD_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arid_q    <= arid_d;
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
`ifdef CACHE_AXI_RD_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  always_comb begin
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    bus.s_rready  = 1'b0;
    bus.s_arvalid = 1'b0;
    unique case (state_q)
      ADDR: begin
        bus.s_arvalid          = 1'b1;
        bus.m_arready[grant_q] = bus.s_arready;
      end
      DATA: begin
        bus.m_rvalid[grant_q] = bus.s_rvalid;
        bus.s_rready          = bus.m_rready[grant_q];
      end
      default: ;
    endcase
  end

  assign bus.s_araddr  = araddr_q;
  assign bus.s_arlen   = arlen_q;
  assign bus.s_arsize  = arsize_q;
  assign bus.s_arburst = arburst_q;
  assign bus.s_arid    = arid_q;
  assign bus.m_rdata   = bus.s_rdata[DATA_WIDTH-1:0];
  assign bus.m_rresp   = bus.s_rresp;
  assign bus.m_rlast   = bus.s_rlast;
  assign bus.m_rid     = bus.s_rid[ID_WIDTH-1:0];
  assign busy          = (state_q != IDLE);
  assign len_err       = len_err_q;
endmodule

// File: tb/tb_cache_axi_rd_arb.sv
// Directed bench for cache_axi_rd_arb; grant-order expectations follow CACHE_AXI_RD_ARB_RR_EN.
module tb_cache_axi_rd_arb;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic len_err;
  int   asserts  = 0;
  int   failures = 0;
  logic [2:0] expOrder [4];

  cache_axi_rd_arb_if #(.N_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  cache_axi_rd_arb #(.N_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.m_arvalid = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arsize  = '0;
    bus.m_arburst = '0;
    bus.m_arid    = '0;
    bus.m_rready  = '0;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;
    bus.s_rlast   = 1'b0;
    bus.s_rid     = '0;
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input logic [3:0] len,
                               input logic [IW-1:0] id);
    bus.m_arvalid[idx]             = 1'b1;
    bus.m_araddr[idx*AW +: AW]     = addr;
    bus.m_arlen[idx*4 +: 4]        = len;
    bus.m_arsize[idx*3 +: 3]       = 3'd2;
    bus.m_arburst[idx*2 +: 2]      = 2'b01;
    bus.m_arid[idx*IW +: IW]       = id;
  endtask

  task automatic driveBeat(input logic [DW-1:0] data, input logic last);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = data;
    bus.s_rlast  = last;
    bus.s_rresp  = 2'b00;
    bus.s_rid    = 4'h5;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    clearInputs();
    nextCycle();
    nextCycle();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_len_err", len_err, 0);
    checkOutput("rst_s_arvalid", bus.s_arvalid, 0);
    checkOutput("rst_s_araddr", bus.s_araddr, 0);
    checkOutput("rst_m_arready", bus.m_arready, 0);
    checkOutput("rst_m_rvalid", bus.m_rvalid, 0);
    checkOutput("rst_s_rready", bus.s_rready, 0);
    rst = 1'b1;
    nextCycle();
  endtask

  // Single-beat burst for one master, used to move the arbiter into a known state.
  task automatic singleBurst(input int idx);
    applyStimulus(idx, 32'h0000_0100, 4'd0, 4'h1);
    nextCycle();
    bus.s_arready = 1'b1;
    nextCycle();
    bus.s_arready = 1'b0;
    bus.m_arvalid = '0;
    bus.m_rready  = '1;
    driveBeat(32'h1, 1'b1);
    nextCycle();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
  endtask

  initial begin
`ifdef CACHE_AXI_RD_ARB_RR_EN
    expOrder[0] = 3'b001; expOrder[1] = 3'b010; expOrder[2] = 3'b100; expOrder[3] = 3'b001;
`else
    expOrder[0] = 3'b001; expOrder[1] = 3'b001; expOrder[2] = 3'b001; expOrder[3] = 3'b001;
`endif
    applyReset();

    // Master 1 alone, 8-beat burst
    applyStimulus(1, 32'h1000_0040, 4'd7, 4'h5);
    #1 checkOutput("a_cycle0_arvalid", bus.s_arvalid, 0);
    nextCycle();
    checkOutput("a_arvalid", bus.s_arvalid, 1);
    checkOutput("a_araddr", bus.s_araddr, 32'h1000_0040);
    checkOutput("a_arlen", bus.s_arlen, 7);
    checkOutput("a_arid", bus.s_arid, 5);
    checkOutput("a_busy", busy, 1);
    bus.s_arready = 1'b1;
    #1 checkOutput("a_m_arready", bus.m_arready, 3'b010);
    nextCycle();
    bus.m_arvalid = '0;
    bus.s_arready = 1'b0;
    bus.m_rready  = '1;
    for (int k = 0; k < 8; k++) begin
      driveBeat(32'hA0 + k, k == 7);
      #1;
      checkOutput("a_m_rvalid", bus.m_rvalid, 3'b010);
      checkOutput("a_s_rready", bus.s_rready, 1);
      checkOutput("a_m_rdata", bus.m_rdata, 32'hA0 + k);
      nextCycle();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    checkOutput("a_done_busy", busy, 0);
    checkOutput("a_done_len_err", len_err, 0);
    checkOutput("a_done_m_rvalid", bus.m_rvalid, 0);

    // AR stall: fields must hold while s_arready is low; stray R beats ignored
    applyStimulus(0, 32'h0000_2000, 4'd0, 4'h1);
    nextCycle();
    bus.s_rvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("b_arvalid", bus.s_arvalid, 1);
      checkOutput("b_araddr", bus.s_araddr, 32'h0000_2000);
      checkOutput("b_m_arready", bus.m_arready, 0);
      checkOutput("b_s_rready", bus.s_rready, 0);
      checkOutput("b_m_rvalid", bus.m_rvalid, 0);
      bus.m_araddr[0 +: AW] = 32'hDEAD_0000;
      nextCycle();
    end
    bus.s_arready = 1'b1;
    #1 checkOutput("b_m_arready_go", bus.m_arready, 3'b001);
    nextCycle();
    bus.s_arready = 1'b0;
    bus.m_arvalid = '0;
    bus.m_rready  = '1;
    driveBeat(32'h55, 1'b1);
    #1 checkOutput("b_m_rvalid", bus.m_rvalid, 3'b001);
    nextCycle();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    checkOutput("b_done_busy", busy, 0);

    // R backpressure from master 2 mid-burst
    applyStimulus(2, 32'h0000_3000, 4'd3, 4'h2);
    nextCycle();
    bus.s_arready = 1'b1;
    nextCycle();
    bus.s_arready = 1'b0;
    bus.m_arvalid = '0;
    bus.m_rready  = '1;
    driveBeat(32'h0, 1'b0);
    nextCycle();
    bus.m_rready = '0;
    driveBeat(32'h1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("c_stall_s_rready", bus.s_rready, 0);
      checkOutput("c_stall_m_rvalid", bus.m_rvalid, 3'b100);
      nextCycle();
    end
    bus.m_rready = '1;
    for (int k = 1; k < 4; k++) begin
      driveBeat(32'(k), k == 3);
      #1 checkOutput("c_s_rready", bus.s_rready, 1);
      nextCycle();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    checkOutput("c_done_busy", busy, 0);
    checkOutput("c_len_err", len_err, 0);

    // Three continuous requesters, back-to-back single-beat bursts
    applyReset();
    applyStimulus(0, 32'h0000_0000, 4'd0, 4'h0);
    applyStimulus(1, 32'h0000_1000, 4'd0, 4'h1);
    applyStimulus(2, 32'h0000_2000, 4'd0, 4'h2);
    bus.m_rready = '1;
    for (int b = 0; b < 4; b++) begin
      nextCycle();
      bus.s_arready = 1'b1;
      #1 checkOutput("d_grant", bus.m_arready, expOrder[b]);
      nextCycle();
      bus.s_arready = 1'b0;
      driveBeat(32'(b), 1'b1);
      nextCycle();
      bus.s_rvalid = 1'b0;
      bus.s_rlast  = 1'b0;
      checkOutput("d_idle_busy", busy, 0);
    end
    clearInputs();

    // Early rlast on the second beat of a 4-beat burst
    applyStimulus(0, 32'h0000_4000, 4'd3, 4'h3);
    nextCycle();
    bus.s_arready = 1'b1;
    nextCycle();
    bus.s_arready = 1'b0;
    bus.m_arvalid = '0;
    bus.m_rready  = '1;
    driveBeat(32'h0, 1'b0);
    nextCycle();
    driveBeat(32'h1, 1'b1);
    #1 checkOutput("e_len_err_before", len_err, 0);
    nextCycle();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    checkOutput("e_len_err_set", len_err, 1);
    checkOutput("e_busy", busy, 0);
    singleBurst(1);
    checkOutput("e_len_err_sticky", len_err, 1);
    applyReset();

    // Reset mid-burst aborts; arbitration restarts from master 0
    singleBurst(1);
    applyStimulus(1, 32'h0000_5000, 4'd7, 4'h4);
    nextCycle();
    bus.s_arready = 1'b1;
    nextCycle();
    bus.s_arready = 1'b0;
    bus.m_arvalid = '0;
    bus.m_rready  = '1;
    for (int k = 0; k < 3; k++) begin
      driveBeat(32'(k), 1'b0);
      nextCycle();
    end
    driveBeat(32'h3, 1'b0);
    #1 rst = 1'b0;
    nextCycle();
    checkOutput("f_busy", busy, 0);
    checkOutput("f_m_rvalid", bus.m_rvalid, 0);
    checkOutput("f_s_rready", bus.s_rready, 0);
    checkOutput("f_len_err", len_err, 0);
    clearInputs();
    rst = 1'b1;
    nextCycle();
    applyStimulus(0, 32'h0000_0000, 4'd0, 4'h0);
    applyStimulus(1, 32'h0000_1000, 4'd0, 4'h1);
    applyStimulus(2, 32'h0000_2000, 4'd0, 4'h2);
    nextCycle();
    bus.s_arready = 1'b1;
    #1 checkOutput("f_grant_after_rst", bus.m_arready, 3'b001);
    nextCycle();
    clearInputs();
    bus.m_rready = '1;
    driveBeat(32'h9, 1'b1);
    nextCycle();
    clearInputs();
    checkOutput("f_final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/cache_axi_rd_arb.md
CACHE_AXI_RD_ARB -- requirements
Module: cache_axi_rd_arb

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3, number of cache read masters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AR address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, R data width.
REQ-004 SHALL have parameter ID_WIDTH, default 4, AXI3 ARID/RID width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port m_arvalid  input  N_MASTERS  per-master AR valid.
REQ-008 SHALL have port m_arready  output  N_MASTERS  per-master AR ready.
REQ-009 SHALL have port m_araddr  input  N_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i.
REQ-010 SHALL have port m_arlen  input  N_MASTERS*4  packed AXI3 burst lengths.
REQ-011 SHALL have port m_arsize/m_arburst  input  N_MASTERS*3 / N_MASTERS*2  packed size/burst.
REQ-012 SHALL have port m_arid  input  N_MASTERS*ID_WIDTH  packed IDs.
REQ-013 SHALL have port m_rvalid  output  N_MASTERS  per-master R valid.
REQ-014 SHALL have port m_rready  input  N_MASTERS  per-master R ready.
REQ-015 SHALL have ports m_rdata/m_rresp/m_rlast/m_rid  output  DATA_WIDTH/2/1/ID_WIDTH  broadcast R payload.
REQ-016 SHALL have ports s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid  output  1/ADDR_WIDTH/4/3/2/ID_WIDTH  AXI3 AR to memory.
REQ-017 SHALL have port s_arready  input  1; s_rvalid, s_rdata, s_rresp, s_rlast, s_rid  input  1/DATA_WIDTH/2/1/ID_WIDTH; s_rready  output  1.
REQ-018 SHALL have port busy  output  1  transaction in flight; len_err  output  1  sticky burst-length mismatch.

Function
REQ-019 SHALL implement FSM IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-020 IDLE: if any m_arvalid, SHALL latch grant index g per arbitration rule and AR fields of g, go ADDR next cycle; else stay.
REQ-021 ADDR: SHALL drive s_arvalid=1 with latched fields; m_arready[g]=s_arready, all others 0; on s_arready go DATA.
REQ-022 DATA: SHALL drive m_rvalid[g]=s_rvalid, others 0; s_rready=m_rready[g]; on s_rvalid&s_rready&s_rlast go IDLE.
REQ-023 SHALL drive s_rready=0 and all m_rvalid=0 outside DATA; R beats arriving then are not consumed.
REQ-024 SHALL count accepted R beats in 4-bit counter cleared on ADDR->DATA.
REQ-025 SHALL set len_err when accepted beat has s_rlast at count!=arlen, or count==arlen without s_rlast; len_err clears only on reset.
REQ-026 m_rdata/m_rresp/m_rlast/m_rid SHALL equal s_ inputs combinationally; busy=1 in ADDR or DATA.
REQ-027 Minimum latency: m_arvalid in IDLE at cycle 0 -> s_arvalid at cycle 1.
REQ-028 arlen=0 SHALL complete with one beat; back-to-back: new grant evaluated in IDLE cycle following last beat.

Reset
REQ-029 While rst=0: state IDLE, grant 0, RR pointer 0, beat count 0, len_err 0, all valid/ready outputs 0, s_ AR fields 0.
REQ-030 Reset asserted mid-burst SHALL abort immediately; no completion signalled to any master.

Configuration
REQ-031 With CACHE_AXI_RD_ARB_RR_EN defined: round-robin; grant first requester at or after pointer, pointer=g+1 (N_MASTERS-1 wraps to 0) on burst completion.
REQ-032 Without CACHE_AXI_RD_ARB_RR_EN: fixed priority, lowest-index requester wins; pointer logic absent.

Verification
REQ-033 Master 1 alone, araddr=0x1000_0040, arlen=7: s_arvalid cycle 1 with addr 0x1000_0040; 8 beats to m_rvalid[1] only; IDLE after rlast; len_err=0.
REQ-034 RR_EN, masters 0,1,2 request continuously, arlen=0: grant order 0,1,2,0; without RR_EN: 0,0,0,0.
REQ-035 s_arready held 0 for 5 cycles in ADDR: s_arvalid and fields stable, m_arready all 0 until s_arready=1.
REQ-036 m_rready[g]=0 for 3 cycles mid-burst: s_rready=0 those cycles, no beat lost, beat count unchanged.
REQ-037 arlen=3, slave asserts rlast on beat 2: len_err=1, FSM IDLE; len_err stays 1 until rst=0.
REQ-038 rst=0 during beat 4 of arlen=7: next cycle busy=0, all m_rvalid=0, RR pointer 0.
